reg_file_sb: RTL and testbench

- Parametrised successor to the core's register file.
- Configurable data width and register count; x0 hardwired to zero; two combinational read ports and one synchronous write port.
- Adds a per-register busy scoreboard: set at instruction issue, cleared at writeback.
- Sits between decode (RA/RB/issue) and writeback (RW/busW) and gives decode stall information.

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 49 ++++
 rtl/reg_file_sb.sv | 77 +++++++
 tb/tb_reg_file_sb.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and popcount helper for reg_file_sb
package reg_file_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ZERO_REG = 0;
    localparam int MAX_NREG = 1024;

    // Callers zero-extend their busy vector to MAX_NREG bits.
    function automatic int unsigned popcount(input logic [MAX_NREG-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_NREG; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits, flush and pending count
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_en,
    input  logic [AW-1:0]   RW,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     pend_cnt
);

    logic [NREG-1:0]     busy_next;
    logic [MAX_NREG-1:0] busy_wide;

    // Clear before set so a same-cycle issue to the written index keeps it busy.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (write_en && RW != AW'(ZERO_REG)) busy_next[RW] = 1'b0;
            if (issue_en && issue_rd != AW'(ZERO_REG)) busy_next[issue_rd] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_comb begin
        busy_wide = '0;
        busy_wide[NREG-1:0] = busy_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_next;
            pend_cnt <= (AW+1)'(popcount(busy_wide));
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with busy scoreboard; REG_FILE_BYPASS_EN enables write-through forwarding
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_en,
    input  logic [AW-1:0]   RW,
    input  logic [XLEN-1:0] busW,
    input  logic [AW-1:0]   RA,
    input  logic [AW-1:0]   RB,
    output logic [XLEN-1:0] busA,
    output logic [XLEN-1:0] busB,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            busy_A,
    output logic            busy_B,
    output logic [AW:0]     pend_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            wr_ok;

    assign wr_ok = write_en && (RW != AW'(ZERO_REG));

    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .RW       (RW),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy     (busy),
        .pend_cnt (pend_cnt)
    );

    // Entry 0 is only ever cleared, so it reads as zero without extra muxing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[RW] <= busW;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        busA   = regs[RA];
        busB   = regs[RB];
        busy_A = busy[RA];
        busy_B = busy[RB];
        if (wr_ok && RW == RA) begin
            busA   = busW;
            busy_A = issue_en && (issue_rd == RA);
        end
        if (wr_ok && RW == RB) begin
            busB   = busW;
            busy_B = issue_en && (issue_rd == RB);
        end
    end
`else
    always_comb begin
        busA   = regs[RA];
        busB   = regs[RB];
        busy_A = busy[RA];
        busy_B = busy[RB];
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized model-checked bench for reg_file_sb
module tb_reg_file_sb;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic          rst, write_en, issue_en, flush, busy_A, busy_B;
    logic [AW-1:0] RW, RA, RB, issue_rd;
    logic [31:0]   busW, busA, busB;
    logic [AW:0]   pend_cnt;

    logic          w_write_en, w_issue_en, w_flush, w_busy_A, w_busy_B;
    logic [3:0]    w_RW, w_RA, w_RB, w_issue_rd;
    logic [63:0]   w_busW, w_busA, w_busB;
    logic [4:0]    w_pend_cnt;

    reg_file_sb #(.XLEN(32), .NREG(32)) u_dut (
        .clk(clk), .rst(rst), .write_en(write_en), .RW(RW), .busW(busW),
        .RA(RA), .RB(RB), .busA(busA), .busB(busB),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
        .busy_A(busy_A), .busy_B(busy_B), .pend_cnt(pend_cnt)
    );

    reg_file_sb #(.XLEN(64), .NREG(16)) u_dut64 (
        .clk(clk), .rst(rst), .write_en(w_write_en), .RW(w_RW), .busW(w_busW),
        .RA(w_RA), .RB(w_RB), .busA(w_busA), .busB(w_busB),
        .issue_en(w_issue_en), .issue_rd(w_issue_rd), .flush(w_flush),
        .busy_A(w_busy_A), .busy_B(w_busy_B), .pend_cnt(w_pend_cnt)
    );

    logic [31:0] mregs [32];
    bit          mbusy [32];
    int          checks = 0;
    int          failures = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int mpend();
        int n = 0;
        foreach (mbusy[i]) if (mbusy[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = '0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (write_en && RW != 0) mregs[RW] = busW;
        if (flush) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
        end else begin
            if (write_en && RW != 0) mbusy[RW] = 1'b0;
            if (issue_en && issue_rd != 0) mbusy[issue_rd] = 1'b1;
        end
    endtask

    task automatic compare();
        logic [31:0] ea, eb;
        logic        ba, bb;
        ea = (RA == 0) ? 32'd0 : mregs[RA];
        eb = (RB == 0) ? 32'd0 : mregs[RB];
        ba = mbusy[RA];
        bb = mbusy[RB];
`ifdef REG_FILE_BYPASS_EN
        if (write_en && RW != 0 && RW == RA) begin
            ea = busW;
            ba = issue_en && issue_rd == RA;
        end
        if (write_en && RW != 0 && RW == RB) begin
            eb = busW;
            bb = issue_en && issue_rd == RB;
        end
`endif
        chk("busA", 64'(busA), 64'(ea));
        chk("busB", 64'(busB), 64'(eb));
        chk("busy_A", 64'(busy_A), 64'(ba));
        chk("busy_B", 64'(busy_B), 64'(bb));
        chk("pend_cnt", 64'(pend_cnt), 64'(mpend()));
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        write_en = 0; issue_en = 0; flush = 0;
        RW = 0; issue_rd = 0; busW = 0;
    endtask

    initial begin
        rst = 1'b1; idle(); RA = 0; RB = 0;
        w_write_en = 0; w_issue_en = 0; w_flush = 0;
        w_RW = 0; w_RA = 0; w_RB = 0; w_issue_rd = 0; w_busW = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_pend", 64'(pend_cnt), 64'd0);

        for (int i = 1; i < 32; i++) begin
            write_en = 1; RW = AW'(i); busW = $urandom;
            issue_en = 1; issue_rd = AW'(i);
            RA = AW'($urandom); RB = AW'($urandom);
            cycle();
        end
        idle();
        #1 rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            RA = AW'(i); RB = AW'(i);
            #1;
            chk("async_rst_busA", 64'(busA), 64'd0);
            chk("async_rst_busB", 64'(busB), 64'd0);
        end
        chk("async_rst_pend", 64'(pend_cnt), 64'd0);
        rst = 1'b0;
        model_reset();

        write_en = 1; RW = 1; busW = 12; RA = 1; cycle(); idle();
        #1 chk("wr_x1", 64'(busA), 64'd12);
        write_en = 1; RW = 0; busW = 14; RB = 0; cycle(); idle();
        #1 chk("wr_x0", 64'(busB), 64'd0);

        issue_en = 1; issue_rd = 5; cycle();
        issue_rd = 7; cycle(); idle();
        RA = 5; #1;
        chk("issue_busyA", 64'(busy_A), 64'd1);
        chk("issue_pend", 64'(pend_cnt), 64'd2);
        write_en = 1; RW = 5; busW = 99; cycle(); idle();
        #1;
        chk("wb_busyA", 64'(busy_A), 64'd0);
        chk("wb_busA", 64'(busA), 64'd99);
        chk("wb_pend", 64'(pend_cnt), 64'd1);

        issue_en = 1; issue_rd = 3; write_en = 1; RW = 3; busW = 33; RA = 3;
        cycle(); idle();
        #1;
        chk("same_busy3", 64'(busy_A), 64'd1);
        chk("same_pend", 64'(pend_cnt), 64'd2);
        issue_en = 1; issue_rd = 10; cycle(); idle();
        #1 chk("pre_flush_pend", 64'(pend_cnt), 64'd3);
        flush = 1; issue_en = 1; issue_rd = 12; cycle(); idle();
        #1 chk("flush_pend", 64'(pend_cnt), 64'd0);
        foreach (mbusy[r]) begin
            RA = AW'(r); RB = AW'(31 - r); #1;
            chk("flush_busyA", 64'(busy_A), 64'd0);
            chk("flush_busyB", 64'(busy_B), 64'd0);
        end

        issue_en = 1; issue_rd = 9; cycle(); idle();
        write_en = 1; RW = 9; RA = 9; busW = 32'hDEADBEEF;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("fwd_busA", 64'(busA), 64'hDEADBEEF);
        chk("fwd_busyA", 64'(busy_A), 64'd0);
`else
        chk("nofwd_busA", 64'(busA), 64'd0);
        chk("nofwd_busyA", 64'(busy_A), 64'd1);
`endif
        cycle(); idle();
        #1 chk("post_wr_x9", 64'(busA), 64'hDEADBEEF);

        repeat (3000) begin
            write_en = 1'($urandom_range(0, 1));
            issue_en = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 39) == 0);
            RW       = AW'($urandom);
            issue_rd = AW'($urandom);
            RA       = AW'($urandom);
            RB       = ($urandom_range(0, 3) == 0) ? RW : AW'($urandom);
            busW     = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
                model_reset();
            end
            cycle();
        end
        idle();

        w_write_en = 1; w_RW = 15; w_busW = 64'hFFFFFFFF00000001;
        @(posedge clk); #1;
        w_write_en = 0; w_RA = 15; #1;
        chk("x64_busA", w_busA, 64'hFFFFFFFF00000001);
        for (int i = 1; i < 16; i++) begin
            w_issue_en = 1; w_issue_rd = 4'(i);
            @(posedge clk); #1;
        end
        w_issue_en = 0; w_RB = 15; #1;
        chk("x64_pend", 64'(w_pend_cnt), 64'd15);
        chk("x64_busyB", 64'(w_busy_B), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
